sram_image_readback: RTL

// - Avalon-MM slave for Nios readback of frame-buffer pixels from the 16-bit

---
 rtl/sram_image_readback.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_image_readback.sv
// rtl/sram_image_readback.sv - Avalon-MM readback of frame-buffer words from async SRAM
//
// Purpose:
//   The CPU programs a start word address and a word count. The block then
//   arbitrates for the SRAM (req/gnt), burst-reads the words into a 16-entry
//   FIFO, and the CPU pops them through the DATA register.
//
// Ports:
//   csi_clk, csi_reset_n           clock, async active-low reset
//   avs_chipselect/address/read/   Avalon-MM slave; readdata is registered,
//   avs_readdata/write/writedata   read latency 1
//   coe_oSRAM_ADDR                 SRAM word address (current read pointer)
//   coe_ioSRAM_DQ                  SRAM data bus, never driven by this block
//   coe_oSRAM_WE_N/OE_N/CE_N/      SRAM strobes; OE/CE/UB/LB low only while a
//   coe_oSRAM_UB_N/LB_N            word is being read, WE_N held high
//   coe_oSRAM_REQ, coe_iSRAM_GNT   arbiter handshake shared with the LCD scan
//   ins_irq                        transfer-done interrupt (only when
//                                  SRAM_READBACK_IRQ_EN is defined)
//
// Register map (avs_address):
//   0 ADDR   R/W  start word address [19:0]
//   1 COUNT  W    starts a transfer when idle and nonzero; R remaining count
//   2 DATA   R    pops one FIFO word, {16'd0, word}; empty -> 0 + underflow
//   3 STATUS R    [0] busy [1] empty [2] full [3] underflow [8+FIFO_AW:8] level
//            W    bit0 abort, bit2 clear irq, bit3 clear underflow

module sram_image_readback #(
  parameter int FIFO_AW     = 4,
  parameter int READ_WAIT   = 2,
  parameter int FRAME_WORDS = 384000
) (
  input  logic        csi_clk,
  input  logic        csi_reset_n,
  input  logic        avs_chipselect,
  input  logic [3:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [19:0] coe_oSRAM_ADDR,
  inout  wire  [15:0] coe_ioSRAM_DQ,
  output logic        coe_oSRAM_WE_N,
  output logic        coe_oSRAM_OE_N,
  output logic        coe_oSRAM_CE_N,
  output logic        coe_oSRAM_UB_N,
  output logic        coe_oSRAM_LB_N,
  output logic        coe_oSRAM_REQ,
`ifdef SRAM_READBACK_IRQ_EN
  output logic        ins_irq,
`endif
  input  logic        coe_iSRAM_GNT
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int LW    = FIFO_AW + 1;
  localparam int WCW   = (READ_WAIT > 2) ? $clog2(READ_WAIT) : 1;

  localparam logic [LW-1:0]  FIFO_DEPTH = LW'(DEPTH);
  localparam logic [19:0]    LAST_ADDR  = 20'(FRAME_WORDS - 1);
  localparam logic [WCW-1:0] WAIT_INIT  = WCW'(READ_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_WAIT, S_CAPTURE, S_HOLD
  } state_e;

  state_e                state_q, state_d;
  logic [WCW-1:0]        wait_q, wait_d;
  logic [19:0]           start_addr_q, start_addr_d;
  logic [19:0]           sram_addr_q, sram_addr_d;
  logic [20:0]           count_q, count_d;
  logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  underflow_q, underflow_d;
  logic [31:0]           readdata_q, readdata_d;
  logic                  irq_q, irq_d;
  logic [15:0]           fifo_mem_q [DEPTH];

  logic wr_sel, rd_sel, abort, start, push, pop;
  logic fifo_empty, fifo_full, sram_active;
  logic [31:0] status;
  logic unused_wdata;

  assign unused_wdata = ^avs_writedata;

  assign wr_sel     = avs_chipselect & avs_write;
  assign rd_sel     = avs_chipselect & avs_read;
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == FIFO_DEPTH);

  // Abort wins over everything else in the same cycle, including a start.
  assign abort = wr_sel && (avs_address == 4'd3) && avs_writedata[0];
  assign start = wr_sel && (avs_address == 4'd1) && (avs_writedata[20:0] != 21'd0)
                 && (state_q == S_IDLE) && !abort;
  assign pop   = rd_sel && (avs_address == 4'd2) && !fifo_empty;
  assign push  = (state_q == S_CAPTURE) && !fifo_full && !abort;

  // FIFO pointers and fill level
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
    end
  end

  // Read FSM
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    sram_addr_d = sram_addr_q;
    count_d     = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_REQ;
          sram_addr_d = start_addr_q;
          count_d     = avs_writedata[20:0];
        end
      end
      S_REQ: begin
        if (coe_iSRAM_GNT) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (!coe_iSRAM_GNT) begin
          state_d = S_REQ;
        end else if (READ_WAIT == 1) begin
          state_d = S_CAPTURE;
        end else begin
          wait_d  = WAIT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Grant loss abandons the word; it is re-read from REQ.
        if (!coe_iSRAM_GNT) begin
          state_d = S_REQ;
        end else begin
          wait_d = wait_q - WCW'(1);
          if (wait_q == WCW'(1)) state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        sram_addr_d = (sram_addr_q == LAST_ADDR) ? 20'd0 : sram_addr_q + 20'd1;
        count_d     = count_q - 21'd1;
        if (count_q == 21'd1)         state_d = S_IDLE;
        else if (level_d == FIFO_DEPTH) state_d = S_HOLD;
        else if (!coe_iSRAM_GNT)      state_d = S_REQ;
        else                          state_d = S_ADDR;
      end
      S_HOLD: begin
        if (!fifo_full) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      count_d = '0;
    end
  end

  // Register file, flags, read data
  always_comb begin
    status               = '0;
    status[0]            = (state_q != S_IDLE);
    status[1]            = fifo_empty;
    status[2]            = fifo_full;
    status[3]            = underflow_q;
    status[8 +: LW]      = level_q;

    start_addr_d = start_addr_q;
    underflow_d  = underflow_q;
    readdata_d   = readdata_q;
    irq_d        = irq_q;

    if (wr_sel && (avs_address == 4'd0)) start_addr_d = avs_writedata[19:0];
    if (wr_sel && (avs_address == 4'd3) && avs_writedata[3]) underflow_d = 1'b0;
`ifdef SRAM_READBACK_IRQ_EN
    if (wr_sel && (avs_address == 4'd3) && avs_writedata[2]) irq_d = 1'b0;
    if (start) irq_d = 1'b0;
    if ((state_q == S_CAPTURE) && (count_q == 21'd1) && !abort) irq_d = 1'b1;
`endif

    if (rd_sel) begin
      case (avs_address)
        4'd0:    readdata_d = {12'd0, start_addr_q};
        4'd1:    readdata_d = {11'd0, count_q};
        4'd2: begin
          if (fifo_empty) begin
            readdata_d  = 32'd0;
            underflow_d = 1'b1;
          end else begin
            readdata_d = {16'd0, fifo_mem_q[rd_ptr_q]};
          end
        end
        4'd3:    readdata_d = status;
        default: readdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      state_q      <= S_IDLE;
      wait_q       <= '0;
      start_addr_q <= '0;
      sram_addr_q  <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      underflow_q  <= 1'b0;
      readdata_q   <= '0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      start_addr_q <= start_addr_d;
      sram_addr_q  <= sram_addr_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      underflow_q  <= underflow_d;
      readdata_q   <= readdata_d;
      irq_q        <= irq_d;
    end
  end

  // FIFO storage needs no reset; the level/pointers define validity.
  always_ff @(posedge csi_clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= coe_ioSRAM_DQ;
  end

  assign sram_active    = (state_q == S_ADDR) || (state_q == S_WAIT) || (state_q == S_CAPTURE);
  assign coe_oSRAM_REQ  = sram_active || (state_q == S_REQ);
  assign coe_oSRAM_OE_N = !sram_active;
  assign coe_oSRAM_CE_N = !sram_active;
  assign coe_oSRAM_UB_N = !sram_active;
  assign coe_oSRAM_LB_N = !sram_active;
  assign coe_oSRAM_WE_N = 1'b1;
  assign coe_oSRAM_ADDR = sram_addr_q;
  assign coe_ioSRAM_DQ  = 16'hzzzz;
  assign avs_readdata   = readdata_q;

`ifdef SRAM_READBACK_IRQ_EN
  assign ins_irq = irq_q;
`else
  logic unused_irq;
  assign unused_irq = irq_q;
`endif

endmodule
